// File: rtl/counter_delay_line.sv
// Counter delay line: byte-swaps a candidate counter at stage 0 and carries it,
// with a valid bit, down a DEPTH-stage chain beside the MD5 round pipeline.
module counter_delay_line #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int TAP_A = 19,
  parameter int TAP_B = 41,
  parameter int TAP_C = 48,
  parameter int BSWAP = 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           counter_in,
  output logic [WIDTH-1:0]           tap_a,
  output logic                       tap_a_valid,
  output logic [WIDTH-1:0]           tap_b,
  output logic                       tap_b_valid,
  output logic [WIDTH-1:0]           tap_c,
  output logic                       tap_c_valid,
  output logic [WIDTH-1:0]           counter_out,
  output logic                       out_valid,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0] vld_p;
  logic [OCC_W-1:0] occ_p;

  function automatic logic [WIDTH-1:0] bswap(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    r = x;
    for (int i = 0; i < WIDTH/8; i++)
      r[8*i +: 8] = x[WIDTH-8-8*i +: 8];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] stage0_word(input logic [WIDTH-1:0] x);
    return (BSWAP != 0) ? bswap(x) : x;
  endfunction

  // Stage 0 capture and stage k <- k-1 shift; bubbles shift like real words.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++)
        data_p[k] <= '0;
      vld_p <= '0;
      occ_p <= '0;
    end else if (flush) begin
      vld_p <= '0;
      occ_p <= '0;
    end else if (en) begin
      data_p[0] <= stage0_word(counter_in);
      for (int k = 1; k < DEPTH; k++)
        data_p[k] <= data_p[k-1];
      vld_p <= {vld_p[DEPTH-2:0], in_valid};
      occ_p <= occ_p + OCC_W'(in_valid) - OCC_W'(vld_p[DEPTH-1]);
    end
  end

  assign tap_a       = data_p[TAP_A];
  assign tap_a_valid = vld_p[TAP_A];
  assign tap_b       = data_p[TAP_B];
  assign tap_b_valid = vld_p[TAP_B];
  assign tap_c       = data_p[TAP_C];
  assign tap_c_valid = vld_p[TAP_C];
  assign counter_out = data_p[DEPTH-1];
  assign out_valid   = vld_p[DEPTH-1];
  assign occupancy   = occ_p;

endmodule

// File: tb/tb_counter_delay_line.sv
// Bench for counter_delay_line: scoreboard of inserted words keyed by capture
// edge, vector table for the byte swap, and hand sequences for stall/flush/reset.
module tb_counter_delay_line;

  localparam int W  = 32;
  localparam int D  = 64;
  localparam int TA = 19;
  localparam int TB = 41;
  localparam int TC = 48;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST, en, flush, in_valid;
  logic [W-1:0] counter_in;
  logic [W-1:0] tap_a, tap_b, tap_c, counter_out;
  logic         tap_a_valid, tap_b_valid, tap_c_valid, out_valid;
  logic [6:0]   occupancy;

  logic         RST2, en2, flush2, in_valid2;
  logic [63:0]  counter_in2, tap_a2, tap_b2, tap_c2, counter_out2;
  logic         tap_a_valid2, tap_b_valid2, tap_c_valid2, out_valid2;
  logic [3:0]   occupancy2;

  counter_delay_line dut (
    .CLK(CLK), .RST(RST), .en(en), .flush(flush), .in_valid(in_valid),
    .counter_in(counter_in),
    .tap_a(tap_a), .tap_a_valid(tap_a_valid),
    .tap_b(tap_b), .tap_b_valid(tap_b_valid),
    .tap_c(tap_c), .tap_c_valid(tap_c_valid),
    .counter_out(counter_out), .out_valid(out_valid),
    .occupancy(occupancy)
  );

  counter_delay_line #(
    .WIDTH(64), .DEPTH(8), .TAP_A(0), .TAP_B(0), .TAP_C(7), .BSWAP(0)
  ) dut2 (
    .CLK(CLK), .RST(RST2), .en(en2), .flush(flush2), .in_valid(in_valid2),
    .counter_in(counter_in2),
    .tap_a(tap_a2), .tap_a_valid(tap_a_valid2),
    .tap_b(tap_b2), .tap_b_valid(tap_b_valid2),
    .tap_c(tap_c2), .tap_c_valid(tap_c_valid2),
    .counter_out(counter_out2), .out_valid(out_valid2),
    .occupancy(occupancy2)
  );

  typedef struct {
    logic [W-1:0] data;
    int           cap;
  } sb_t;

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] exp;
  } vec_t;

  sb_t          sb[$];
  vec_t         vt[6];
  int           adv = 0;
  int           nchk = 0;
  int           nerr = 0;
  logic [W-1:0] exp_in;

  function automatic logic [W-1:0] ref_swap(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = {<<8{x}};
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outputs();
    logic         va, vb, vc, vo;
    logic [W-1:0] da, db, dc, dd;
    va = 0; vb = 0; vc = 0; vo = 0;
    da = '0; db = '0; dc = '0; dd = '0;
    foreach (sb[i]) begin
      if (adv - sb[i].cap == TA)    begin va = 1; da = sb[i].data; end
      if (adv - sb[i].cap == TB)    begin vb = 1; db = sb[i].data; end
      if (adv - sb[i].cap == TC)    begin vc = 1; dc = sb[i].data; end
      if (adv - sb[i].cap == D - 1) begin vo = 1; dd = sb[i].data; end
    end
    chk("occupancy", 64'(occupancy), 64'(sb.size()));
    chk("tap_a_valid", 64'(tap_a_valid), 64'(va));
    chk("tap_b_valid", 64'(tap_b_valid), 64'(vb));
    chk("tap_c_valid", 64'(tap_c_valid), 64'(vc));
    chk("out_valid", 64'(out_valid), 64'(vo));
    if (va) chk("tap_a", 64'(tap_a), 64'(da));
    if (vb) chk("tap_b", 64'(tap_b), 64'(db));
    if (vc) chk("tap_c", 64'(tap_c), 64'(dc));
    if (vo) chk("counter_out", 64'(counter_out), 64'(dd));
  endtask

  // One clock: model the edge from the inputs driven before it, then compare.
  task automatic tick();
    logic         rs, fl, ae, iv;
    logic [W-1:0] ex;
    rs = RST; fl = flush; ae = en; iv = in_valid; ex = exp_in;
    @(posedge CLK);
    #1;
    if (rs || fl) begin
      sb.delete();
    end else if (ae) begin
      if (sb.size() > 0 && adv - sb[0].cap == D - 1) void'(sb.pop_front());
      adv++;
      if (iv) sb.push_back('{data: ex, cap: adv});
    end
    check_outputs();
  endtask

  task automatic drive(input logic iv, input logic [W-1:0] din);
    in_valid   = iv;
    counter_in = din;
    exp_in     = ref_swap(din);
  endtask

  int           n;
  int           first_a, first_b, first_c, first_o;
  int           cnt_a, cnt_b, cnt_c, cnt_o;
  logic [W-1:0] ha, hb, hc, ho;

  initial begin
    vt[0] = '{din: 32'h01020304, exp: 32'h04030201};
    vt[1] = '{din: 32'hDEADBEEF, exp: 32'hEFBEADDE};
    vt[2] = '{din: 32'h00000000, exp: 32'h00000000};
    vt[3] = '{din: 32'hFFFFFFFF, exp: 32'hFFFFFFFF};
    vt[4] = '{din: 32'h000000FF, exp: 32'hFF000000};
    vt[5] = '{din: 32'h12345678, exp: 32'h78563412};

    RST = 1; en = 0; flush = 0; drive(0, '0);
    RST2 = 1; en2 = 0; flush2 = 0; in_valid2 = 0; counter_in2 = '0;
    tick();
    chk("rst_tap_a", 64'(tap_a), 0);
    chk("rst_tap_b", 64'(tap_b), 0);
    chk("rst_tap_c", 64'(tap_c), 0);
    chk("rst_counter_out", 64'(counter_out), 0);
    RST = 0; RST2 = 0; en = 1;

    // Single word: each tap valid for exactly one edge at the right latency.
    drive(1, 32'h01020304);
    tick();
    drive(0, '0);
    first_a = 0; first_b = 0; first_c = 0; first_o = 0;
    cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_o = 0;
    for (int e = 2; e <= 66; e++) begin
      tick();
      if (tap_a_valid) begin cnt_a++; if (first_a == 0) first_a = e; end
      if (tap_b_valid) begin cnt_b++; if (first_b == 0) first_b = e; end
      if (tap_c_valid) begin cnt_c++; if (first_c == 0) first_c = e; end
      if (out_valid)   begin cnt_o++; if (first_o == 0) first_o = e; end
      if (e == 64) chk("occ_edge64", 64'(occupancy), 1);
      if (e == 65) chk("occ_edge65", 64'(occupancy), 0);
    end
    chk("tap_a_edge", 64'(first_a), 20);
    chk("tap_b_edge", 64'(first_b), 42);
    chk("tap_c_edge", 64'(first_c), 49);
    chk("out_edge", 64'(first_o), 64);
    chk("valid_pulses", 64'(cnt_a + cnt_b + cnt_c + cnt_o), 4);

    // Byte-swap vectors with independently written expected words.
    foreach (vt[i]) begin
      in_valid = 1; counter_in = vt[i].din; exp_in = vt[i].exp;
      tick();
    end
    drive(0, '0);
    repeat (D + 2) tick();

    // Five-edge stall with the word at stage 10; junk on the inputs is ignored.
    drive(1, 32'hA5A55A5A);
    tick();
    drive(0, '0);
    repeat (10) tick();
    ha = tap_a; hb = tap_b; hc = tap_c; ho = counter_out;
    en = 0; drive(1, 32'h0BADF00D);
    repeat (5) begin
      tick();
      chk("stall_tap_a", 64'(tap_a), 64'(ha));
      chk("stall_tap_b", 64'(tap_b), 64'(hb));
      chk("stall_tap_c", 64'(tap_c), 64'(hc));
      chk("stall_out", 64'(counter_out), 64'(ho));
      chk("stall_occ", 64'(occupancy), 1);
    end
    en = 1; drive(0, '0);
    n = 15;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk("stall_latency", 64'(n), 68);
    repeat (3) tick();

    // Back-to-back stream 0..69: occupancy saturates, output has no gaps.
    for (int i = 0; i < 70; i++) begin
      drive(1, W'(i));
      tick();
      if (i >= 63) chk("stream_occ_sat", 64'(occupancy), 64);
    end
    drive(0, '0);
    repeat (D + 2) tick();

    // Flush after 30 words, then a fresh word passes through normally.
    for (int i = 0; i < 30; i++) begin drive(1, W'(32'h100 + i)); tick(); end
    drive(0, '0); flush = 1;
    tick();
    flush = 0;
    chk("flush_occ", 64'(occupancy), 0);
    chk("flush_valids", 64'({tap_a_valid, tap_b_valid, tap_c_valid, out_valid}), 0);
    drive(1, 32'hCAFEF00D);
    tick();
    drive(0, '0);
    n = 1;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk("post_flush_latency", 64'(n), 64);
    tick();

    // Flush while stalled still clears.
    repeat (3) begin drive(1, 32'h77); tick(); end
    drive(0, '0); en = 0; flush = 1;
    tick();
    chk("flush_stalled_occ", 64'(occupancy), 0);
    flush = 0; en = 1;

    // Reset mid-stream overrides flush and en=0.
    for (int i = 0; i < 50; i++) begin drive(1, W'(32'h55AA0000 + i)); tick(); end
    RST = 1; flush = 1; en = 0;
    tick();
    chk("rst_mid_tap_a", 64'(tap_a), 0);
    chk("rst_mid_tap_b", 64'(tap_b), 0);
    chk("rst_mid_tap_c", 64'(tap_c), 0);
    chk("rst_mid_out", 64'(counter_out), 0);
    chk("rst_mid_valids", 64'({tap_a_valid, tap_b_valid, tap_c_valid, out_valid}), 0);
    RST = 0; flush = 0; en = 1; drive(0, '0);
    tick();

    // Parameter sweep instance: no swap, 64-bit, 8 stages.
    en2 = 1; in_valid2 = 1; counter_in2 = 64'h1122334455667788;
    tick();
    in_valid2 = 0; counter_in2 = 64'hFFFF0000FFFF0000;
    chk("sw_tap_a", tap_a2, 64'h1122334455667788);
    chk("sw_tap_b", tap_b2, 64'h1122334455667788);
    chk("sw_ab_valid", 64'({tap_a_valid2, tap_b_valid2}), 64'b11);
    chk("sw_occ1", 64'(occupancy2), 1);
    repeat (6) tick();
    chk("sw_c_valid_early", 64'({tap_c_valid2, out_valid2}), 0);
    tick();
    chk("sw_tap_c", tap_c2, 64'h1122334455667788);
    chk("sw_out", counter_out2, 64'h1122334455667788);
    chk("sw_c_valid", 64'({tap_c_valid2, out_valid2, tap_a_valid2}), 64'b110);
    tick();
    chk("sw_occ0", 64'(occupancy2), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/counter_delay_line.md
Name: counter_delay_line

Overview:
- Parametrised successor to the fixed 64-stage counter pipeline in the MD5 brute-force datapath.
- Byte-swaps an incoming candidate counter and carries it down a DEPTH-stage register chain that runs alongside the MD5 round pipeline.
- Exposes three taps at configurable stages plus the final stage. Each word carries a valid bit.
- Adds global stall (en), flush and an occupancy counter, so the hash core can be back-pressured and drained.

Parameters:
- WIDTH, 32, counter width in bits; must be a multiple of 8 when BSWAP=1.
- DEPTH, 64, number of pipeline stages (stage 0 .. DEPTH-1); must be at least 2.
- TAP_A, 19, stage index driving tap_a; 0 <= TAP_A < DEPTH.
- TAP_B, 41, stage index driving tap_b; same range.
- TAP_C, 48, stage index driving tap_c; same range. Taps may be in any order and may coincide.
- BSWAP, 1, 1 = reverse byte order at stage 0; 0 = pass through unchanged.

Ports:
- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous reset, active-high.
- en  in  1  advance enable; 0 = every stage holds data and valid.
- flush  in  1  clears all valid bits; data registers untouched.
- in_valid  in  1  counter_in carries a word to insert.
- counter_in  in  WIDTH  candidate counter.
- tap_a  out  WIDTH  stage TAP_A data.
- tap_a_valid  out  1  stage TAP_A valid.
- tap_b  out  WIDTH  stage TAP_B data.
- tap_b_valid  out  1  stage TAP_B valid.
- tap_c  out  WIDTH  stage TAP_C data.
- tap_c_valid  out  1  stage TAP_C valid.
- counter_out  out  WIDTH  stage DEPTH-1 data.
- out_valid  out  1  stage DEPTH-1 valid.
- occupancy  out  $clog2(DEPTH+1)  number of valid stages currently held.

Behaviour:
- Reset: on a rising edge with RST=1, all stage data, all valid bits and occupancy go to 0. All outputs therefore read 0. RST overrides flush and en.
- Stage 0 on an advancing edge (en=1, RST=0, flush=0):
  - data0 <= bswap(counter_in) when BSWAP=1, else counter_in.
  - valid0 <= in_valid.
  - bswap maps byte i to byte WIDTH/8-1-i; for WIDTH=32, 0x01020304 becomes 0x04030201.
- Stage k>0 on an advancing edge: data_k <= data_(k-1), valid_k <= valid_(k-1). Data shifts regardless of valid; invalid slots are bubbles.
- Latency: a word sampled on advancing edge t is visible on stage k after advancing edge t+k, i.e. k+1 advancing edges including capture. Tap stage 19 = 20 edges; DEPTH-1 = 64 edges.
- Stall: en=0 holds all data, valid and occupancy; counter_in and in_valid are ignored. No word is lost or duplicated across a stall of any length.
- Flush (RST=0, flush=1): all valid bits and occupancy go to 0 on that edge. Data registers and in_valid are ignored. Flush wins over en; flush with en=0 still clears.
- Outputs are direct register reads, with no combinational path from inputs.
- occupancy on an advancing edge: next = occupancy + in_valid - valid_(DEPTH-1).
  - Simultaneous insert and exit leaves the count unchanged.
  - The count never exceeds DEPTH and never underflows.
  - It always equals the popcount of the valid bits.
- There is no full or empty back-pressure. The pipeline always accepts when en=1, and the word at stage DEPTH-1 is dropped on the next advancing edge.

Test Plan:
- Reset, then with en=1 present 0x01020304 with in_valid for one cycle:
  - tap_a=0x04030201, valid high exactly 1 cycle, after edge 20.
  - tap_b the same after edge 42; tap_c after edge 49.
  - counter_out/out_valid after edge 64; occupancy reads 1 from edge 1 through edge 64, then 0 after edge 65.
- Same stimulus, but drop en for 5 cycles when the word sits at stage 10:
  - all arrivals shift by exactly 5 edges.
  - tap values are held constant during the stall.
  - occupancy stays 1.
- Stream counters 0..69 back-to-back with in_valid=1:
  - occupancy saturates at 64 from edge 64 onward.
  - counter_out shows bswap(0), bswap(1), ... on consecutive cycles with no gaps.
- Fill with 30 words, assert flush for one cycle:
  - every *_valid and occupancy reads 0 next cycle.
  - a new word inserted the cycle after flush emerges normally at edge 64.
- Assert RST mid-stream together with flush and en=0: every output reads 0 after that edge.
- Parameter sweep BSWAP=0, WIDTH=64, DEPTH=8, TAP_A=TAP_B=0, TAP_C=7:
  - input 0x1122334455667788 appears unswapped on tap_a and tap_b after edge 1, on tap_c and counter_out after edge 8.
